// File: rtl/gray_downscale_2x2_pkg.sv
// Shared constants and types for the 2x2 gray box-average downscaler.
package gray_downscale_2x2_pkg;

    // Rounding offset and shift for the 4-pixel average.
    localparam int unsigned DS_ROUND = 2;
    localparam int unsigned DS_SHIFT = 2;

    // Parity of the current input line within a frame.
    typedef enum logic {
        LINE_EVEN = 1'b0,
        LINE_ODD  = 1'b1
    } line_par_e;

    // Width of a horizontal pair sum (left + right).
    function automatic int unsigned ds_sum_width(input int unsigned dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/gray_downscale_2x2_if.sv
// Pixel-pair input stream and averaged-pixel output stream of the downscaler.
interface gray_downscale_2x2_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_frame_start;
    logic                    in_line_last;
    logic [2*DATA_WIDTH-1:0] in_gray;

    logic                    out_valid;
    logic                    out_frame_start;
    logic                    out_line_last;
    logic [DATA_WIDTH-1:0]   out_gray;
    logic                    out_overflow;

    // Upstream source / downstream sink side.
    modport master (
        output in_valid, in_frame_start, in_line_last, in_gray,
        input  out_valid, out_frame_start, out_line_last, out_gray, out_overflow
    );

    // Downscaler side.
    modport slave (
        input  in_valid, in_frame_start, in_line_last, in_gray,
        output out_valid, out_frame_start, out_line_last, out_gray, out_overflow
    );
endinterface

// File: rtl/gray_ds_linebuf.sv
// One-line buffer of pair sums: simple dual-port RAM with registered read.
module gray_ds_linebuf
    import gray_downscale_2x2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_H_BEATS = 320,
    parameter int unsigned ADDR_WIDTH  = 9,
    localparam int unsigned SW = ds_sum_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [SW-1:0]         wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [SW-1:0]         rdata_o
);

    logic [SW-1:0] mem_q [MAX_H_BEATS];
    logic [SW-1:0] rdata_q;

    // Write port: stores even-line pair sums.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: one-cycle registered read for odd lines.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gray_downscale_2x2.sv
// Streaming 2x2 box-average downscaler: buffers even-line pair sums and
// emits one rounded average per odd-line beat, two cycles later.
module gray_downscale_2x2
    import gray_downscale_2x2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_H_BEATS = 320,
    parameter int unsigned ADDR_WIDTH  = 9
) (
    input logic                 clk,
    input logic                 rst,
    gray_downscale_2x2_if.slave bus
);

    localparam int unsigned SW = ds_sum_width(DATA_WIDTH);
    localparam int unsigned AW = DATA_WIDTH + 2;
    // One extra bit so the column can sit at MAX_H_BEATS even when it equals 2^ADDR_WIDTH.
    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [CW-1:0] col_q, col_d, col_eff;
    line_par_e     par_q, par_d, par_eff;
    logic          started_q, started_d;
    logic          ovf_q, ovf_d;
    logic          first_q, first_d;
    logic          beat, drop, wr_en, rd_en;
    logic [SW-1:0] ps;
    logic [SW-1:0] s0;

    logic          s1_valid_q, s1_last_q, s1_first_q;
    logic [SW-1:0] s1_ps_q;

    logic                  out_valid_q, out_fs_q, out_ll_q;
    logic [DATA_WIDTH-1:0] out_gray_q;
    logic [AW-1:0]         sum4;

    // Beat qualification and next-state for column, parity and frame flags.
    always_comb begin
        ps      = SW'(bus.in_gray[DATA_WIDTH-1:0]) + SW'(bus.in_gray[2*DATA_WIDTH-1:DATA_WIDTH]);
        col_eff = bus.in_frame_start ? '0 : col_q;
        par_eff = bus.in_frame_start ? LINE_EVEN : par_q;
        beat    = bus.in_valid && (started_q || bus.in_frame_start);
        drop    = (col_eff >= CW'(MAX_H_BEATS));
        wr_en   = beat && !drop && (par_eff == LINE_EVEN);
        rd_en   = beat && !drop && (par_eff == LINE_ODD);

        col_d     = col_q;
        par_d     = par_q;
        started_d = started_q;
        ovf_d     = ovf_q;
        first_d   = first_q;
        if (beat) begin
            started_d = 1'b1;
            if (bus.in_frame_start) begin
                ovf_d   = 1'b0;
                first_d = 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
            // A frame-start beat is always even, so rd_en never collides with it.
            if (rd_en) begin
                first_d = 1'b0;
            end
            if (bus.in_line_last) begin
                col_d = '0;
                par_d = (par_eff == LINE_EVEN) ? LINE_ODD : LINE_EVEN;
            end else begin
                col_d = drop ? col_eff : col_eff + CW'(1);
                par_d = par_eff;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            par_q     <= LINE_EVEN;
            started_q <= 1'b0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            col_q     <= col_d;
            par_q     <= par_d;
            started_q <= started_d;
            ovf_q     <= ovf_d;
            first_q   <= first_d;
        end
    end

    gray_ds_linebuf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_H_BEATS (MAX_H_BEATS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (col_eff[ADDR_WIDTH-1:0]),
        .wdata_i (ps),
        .re_i    (rd_en),
        .raddr_i (col_eff[ADDR_WIDTH-1:0]),
        .rdata_o (s0)
    );

    // Stage 1: hold the odd-line pair sum and sidebands alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_ps_q    <= '0;
        end else begin
            s1_valid_q <= rd_en;
            s1_last_q  <= bus.in_line_last;
            s1_first_q <= first_q;
            s1_ps_q    <= ps;
        end
    end

    assign sum4 = AW'(s0) + AW'(s1_ps_q) + AW'(DS_ROUND);

    // Stage 2: rounded average and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_fs_q    <= 1'b0;
            out_ll_q    <= 1'b0;
            out_gray_q  <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_fs_q    <= s1_valid_q && s1_first_q;
            out_ll_q    <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_gray_q <= DATA_WIDTH'(sum4 >> DS_SHIFT);
            end
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_frame_start = out_fs_q;
    assign bus.out_line_last   = out_ll_q;
    assign bus.out_gray        = out_gray_q;
    assign bus.out_overflow    = ovf_q;

endmodule
